// File: rtl/mips_ctrl_pkg.sv
// Shared state codes, opcodes, ALU-op codes and control-word layout for the multicycle
// MIPS controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // Raw per-state control word; handshake gating is applied in the top module.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_multicycle_controller_outdec.sv
// Combinational state -> control-word decode for the multicycle MIPS controller.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_slt,
  output logic [CTRL_W-1:0]  o_ctrl
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (i_state)
      STATE_W'(FETCH): begin
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(DECODE): begin
        w_ctrl.alu_src_b = 2'b11;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(MEMADR): begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
      end
      STATE_W'(MEMRD): w_ctrl.iord = 1'b1;
      STATE_W'(MEMWB): begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      STATE_W'(MEMWR): begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      STATE_W'(EXECUTE): begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b00;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(ALUWB): begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      STATE_W'(BRANCH): begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_src    = 2'b01;
        w_ctrl.branch    = 1'b1;
      end
      STATE_W'(IMMEXEC): begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = i_slt ? ALUOP_SLT : ALUOP_ADD;
      end
      STATE_W'(IMMWB): w_ctrl.reg_write = 1'b1;
      STATE_W'(JUMP): begin
        w_ctrl.pc_src   = 2'b10;
        w_ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath, with memory-wait timeout.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes and expose o_illegal_op.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_iord,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_src,
  output logic       o_pc_write,
  output logic       o_branch,
  output logic [1:0] o_alu_op,
  output logic       o_mem_err
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       o_illegal_op
`endif
);

  localparam int unsigned CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [31:0] TO_LAST = (MEM_TIMEOUT > 0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic               r_slt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_wait_cnt_next;
  logic               w_wait_state;
  logic               w_stall;
  logic               w_timeout;
  logic [CTRL_W-1:0]  w_ctrl_bits;
  ctrl_t              w_ctrl;

  assign w_wait_state = (r_state == STATE_W'(FETCH)) || (r_state == STATE_W'(MEMRD)) ||
                        (r_state == STATE_W'(MEMWR));
  assign w_stall      = w_wait_state && !i_mem_ready;
  // The cycle in which the stall count would reach MEM_TIMEOUT is the timeout cycle.
  assign w_timeout    = (MEM_TIMEOUT > 0) && w_stall && (32'(r_wait_cnt) == TO_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STATE_W'(FETCH): if (i_mem_ready) w_state_next = STATE_W'(DECODE);
      STATE_W'(DECODE): begin
        case (i_opcode)
          OP_LW, OP_SW:     w_state_next = STATE_W'(MEMADR);
          OP_RTYPE:         w_state_next = STATE_W'(EXECUTE);
          OP_BEQ:           w_state_next = STATE_W'(BRANCH);
          OP_ADDI, OP_SLTI: w_state_next = STATE_W'(IMMEXEC);
          OP_J:             w_state_next = STATE_W'(JUMP);
`ifdef ILLEGAL_OP_TRAP_EN
          default:          w_state_next = STATE_W'(TRAP);
`else
          default:          w_state_next = STATE_W'(FETCH);
`endif
        endcase
      end
      STATE_W'(MEMADR):
        w_state_next = (i_opcode == OP_SW) ? STATE_W'(MEMWR) : STATE_W'(MEMRD);
      STATE_W'(MEMRD):   if (i_mem_ready) w_state_next = STATE_W'(MEMWB);
      STATE_W'(MEMWR):   if (i_mem_ready) w_state_next = STATE_W'(FETCH);
      STATE_W'(EXECUTE): w_state_next = STATE_W'(ALUWB);
      STATE_W'(IMMEXEC): w_state_next = STATE_W'(IMMWB);
`ifdef ILLEGAL_OP_TRAP_EN
      STATE_W'(TRAP):    w_state_next = STATE_W'(TRAP);
`endif
      default:           w_state_next = STATE_W'(FETCH);
    endcase
    if (w_timeout) w_state_next = STATE_W'(FETCH);
  end

  always_comb begin
    w_wait_cnt_next = '0;
    if (w_stall && !w_timeout) begin
      w_wait_cnt_next = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= STATE_W'(FETCH);
      r_wait_cnt <= '0;
      r_slt      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (r_state == STATE_W'(DECODE)) r_slt <= (i_opcode == OP_SLTI);
    end
  end

  mips_ctrl_outdec #(
    .STATE_W(STATE_W)
  ) u_outdec (
    .i_state(r_state),
    .i_slt  (r_slt),
    .o_ctrl (w_ctrl_bits)
  );

  assign w_ctrl = ctrl_t'(w_ctrl_bits);

  assign o_iord       = w_ctrl.iord;
  assign o_mem_write  = w_ctrl.mem_write & i_mem_ready;
  assign o_ir_write   = w_ctrl.ir_write & i_mem_ready;
  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_alu_src_a  = w_ctrl.alu_src_a;
  assign o_alu_src_b  = w_ctrl.alu_src_b;
  assign o_pc_src     = w_ctrl.pc_src;
  // Only the fetch PC increment waits on memory; the jump PC load is unconditional.
  assign o_pc_write   = w_ctrl.pc_write & (i_mem_ready | (r_state != STATE_W'(FETCH)));
  assign o_branch     = w_ctrl.branch;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_mem_err    = w_timeout;
`ifdef ILLEGAL_OP_TRAP_EN
  assign o_illegal_op = (r_state == STATE_W'(TRAP));
`endif

endmodule
